// File: rtl/order_map_reader_pkg.sv
// Shared types and constants for the order map read/modify path.
// The map entry layout must match the add-side writer exactly.
package order_map_reader_pkg;

  typedef struct packed {
    logic [15:0] locate;
    logic [31:0] price;
    logic [31:0] shares;
    logic        buySell;
  } orderDataType;

  // The add side treats this ref as a free slot; probing must skip past it.
  localparam logic [63:0] TOMBSTONE_REF = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    COMPARE,
    WRITE
  } stateType;

endpackage

// File: rtl/order_map_hash.sv
// Combinational slot hash: XOR of the four low ADDR_BITS-wide slices of the ref.
// Instantiated by both the add side and the reader so both stay bit-identical.
module order_map_hash #(
  parameter int ADDR_BITS = 12
) (
  input  logic [63:0]          refNum,
  output logic [ADDR_BITS-1:0] slot
);

  logic unusedRefBits;

  assign slot = refNum[ADDR_BITS-1:0]
              ^ refNum[2*ADDR_BITS-1:ADDR_BITS]
              ^ refNum[3*ADDR_BITS-1:2*ADDR_BITS]
              ^ refNum[4*ADDR_BITS-1:3*ADDR_BITS];

  // Upper ref bits do not take part in the hash for small maps.
  assign unusedRefBits = ^refNum;

endmodule

// File: rtl/order_map_reader.sv
// Delete/execute side of the order map: hashes the ref, linear-probes port B,
// reports the stored order and tombstones or shrinks the entry on a hit.
module order_map_reader
  import order_map_reader_pkg::*;
#(
  parameter  int ORDER_MAP_DEPTH = 4096,
  parameter  int MAX_PROBES      = 16,
  localparam int ADDR_BITS       = $clog2(ORDER_MAP_DEPTH)
) (
  input  logic                 clkIn,
  input  logic                 rstNIn,
  input  logic                 delValidIn,
  input  logic                 execValidIn,
  input  logic [63:0]          refNumIn,
  input  logic [31:0]          execSharesIn,
  output logic                 readyOut,
  output logic [ADDR_BITS-1:0] ramAddrOut,
  input  logic [63:0]          ramRefDataIn,
  input  orderDataType         ramOrderDataIn,
  output logic                 ramWrEnOut,
  output logic [63:0]          ramRefDataOut,
  output orderDataType         ramOrderDataOut,
  output logic                 delExecValidOut,
  output logic [15:0]          locateOut,
  output logic [31:0]          priceOut,
  output logic [31:0]          sharesOut,
  output logic                 buySellOut,
  output logic                 notFoundOut
);

  localparam int CNT_W = $clog2(MAX_PROBES + 1);

  stateType             state, stateNext;
  logic [63:0]          refQ;
  logic                 isDelQ;
  logic [31:0]          execSharesQ;
  logic [CNT_W-1:0]     probeCnt, cntNext;
  logic [ADDR_BITS-1:0] hashSlot;
  logic                 accept, isHit, isEmpty, probeExhausted;
  logic [31:0]          takeShares, remShares;
  orderDataType         updOrder;

  order_map_hash #(.ADDR_BITS(ADDR_BITS)) uHash (
    .refNum (refNumIn),
    .slot   (hashSlot)
  );

  always_comb begin
    accept         = (state == IDLE) && (delValidIn || execValidIn);
    isHit          = (ramRefDataIn == refQ);
    isEmpty        = (ramRefDataIn == 64'd0);
    cntNext        = probeCnt + CNT_W'(1);
    probeExhausted = (cntNext == CNT_W'(MAX_PROBES));
    // Execute never removes more than is stored, so remaining cannot underflow.
    if (isDelQ || (ramOrderDataIn.shares <= execSharesQ))
      takeShares = ramOrderDataIn.shares;
    else
      takeShares = execSharesQ;
    remShares       = ramOrderDataIn.shares - takeShares;
    updOrder        = ramOrderDataIn;
    updOrder.shares = remShares;
  end

  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext   = state;
    notFoundOut = 1'b0;
    readyOut    = (state == IDLE);
    case (state)
      IDLE:    if (accept) stateNext = ISSUE;
      ISSUE:   stateNext = WAIT;
      WAIT:    stateNext = COMPARE;
      COMPARE: begin
        if (isHit) begin
          stateNext = WRITE;
        end else if (isEmpty || probeExhausted) begin
          notFoundOut = 1'b1;
          stateNext   = IDLE;
        end else begin
          stateNext = ISSUE;
        end
      end
      WRITE:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      refQ            <= '0;
      isDelQ          <= 1'b0;
      execSharesQ     <= '0;
      probeCnt        <= '0;
      ramAddrOut      <= '0;
      ramWrEnOut      <= 1'b0;
      ramRefDataOut   <= '0;
      ramOrderDataOut <= '0;
      delExecValidOut <= 1'b0;
      locateOut       <= '0;
      priceOut        <= '0;
      sharesOut       <= '0;
      buySellOut      <= 1'b0;
    end else begin
      ramWrEnOut      <= 1'b0;
      delExecValidOut <= 1'b0;
      if (accept) begin
        refQ        <= refNumIn;
        isDelQ      <= delValidIn;
        execSharesQ <= execSharesIn;
        probeCnt    <= '0;
        ramAddrOut  <= hashSlot;
      end
      if (state == COMPARE) begin
        if (isHit) begin
          ramWrEnOut      <= 1'b1;
          delExecValidOut <= 1'b1;
          locateOut       <= ramOrderDataIn.locate;
          priceOut        <= ramOrderDataIn.price;
          sharesOut       <= takeShares;
          buySellOut      <= ramOrderDataIn.buySell;
          if (isDelQ || (remShares == 32'd0)) begin
            ramRefDataOut   <= TOMBSTONE_REF;
            ramOrderDataOut <= '0;
          end else begin
            ramRefDataOut   <= refQ;
            ramOrderDataOut <= updOrder;
          end
        end else if (!isEmpty) begin
          // Power-of-two depth: the natural overflow wraps depth-1 to 0.
          ramAddrOut <= ramAddrOut + ADDR_BITS'(1);
          probeCnt   <= cntNext;
        end
      end
    end
  end

endmodule

// File: tb/tb_order_map_reader.sv
// Directed bench for order_map_reader with a 2-cycle-latency port-B RAM model
// and a simple port-A loader; DEPTH 16, MAX_PROBES 4.
module tb_order_map_reader;
  import order_map_reader_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic         clkIn, rstNIn;
  logic         delValidIn, execValidIn;
  logic [63:0]  refNumIn;
  logic [31:0]  execSharesIn;
  logic         readyOut;
  logic [AW-1:0] ramAddrOut;
  logic [63:0]  ramRefDataIn;
  orderDataType ramOrderDataIn;
  logic         ramWrEnOut;
  logic [63:0]  ramRefDataOut;
  orderDataType ramOrderDataOut;
  logic         delExecValidOut;
  logic [15:0]  locateOut;
  logic [31:0]  priceOut, sharesOut;
  logic         buySellOut, notFoundOut;

  logic [63:0]  memRef [DEPTH];
  orderDataType memOrd [DEPTH];
  logic [AW-1:0] addrQ;
  int           wrCount;
  logic         paWe;
  logic [AW-1:0] paAddr;
  logic [63:0]  paRef;
  orderDataType paOrd;

  int vectors = 0;
  int miscompares = 0;

  order_map_reader #(.ORDER_MAP_DEPTH(DEPTH), .MAX_PROBES(4)) dut (
    .clkIn(clkIn), .rstNIn(rstNIn),
    .delValidIn(delValidIn), .execValidIn(execValidIn),
    .refNumIn(refNumIn), .execSharesIn(execSharesIn),
    .readyOut(readyOut), .ramAddrOut(ramAddrOut),
    .ramRefDataIn(ramRefDataIn), .ramOrderDataIn(ramOrderDataIn),
    .ramWrEnOut(ramWrEnOut), .ramRefDataOut(ramRefDataOut),
    .ramOrderDataOut(ramOrderDataOut), .delExecValidOut(delExecValidOut),
    .locateOut(locateOut), .priceOut(priceOut), .sharesOut(sharesOut),
    .buySellOut(buySellOut), .notFoundOut(notFoundOut)
  );

  initial begin
    clkIn = 1'b0;
    forever #5 clkIn = ~clkIn;
  end

  // Port B: address registered once, data registered again -> 2-cycle latency.
  always @(posedge clkIn) begin
    addrQ          <= ramAddrOut;
    ramRefDataIn   <= memRef[addrQ];
    ramOrderDataIn <= memOrd[addrQ];
    if (paWe) begin
      memRef[paAddr] <= paRef;
      memOrd[paAddr] <= paOrd;
    end
    if (ramWrEnOut) begin
      memRef[ramAddrOut] <= ramRefDataOut;
      memOrd[ramAddrOut] <= ramOrderDataOut;
      wrCount <= wrCount + 1;
    end
  end

  task automatic paWrite(input int slot, input logic [63:0] r, input orderDataType o);
    @(negedge clkIn);
    paWe = 1'b1; paAddr = AW'(slot); paRef = r; paOrd = o;
    @(negedge clkIn);
    paWe = 1'b0;
  endtask

  // Presents a request before edge 0; returns 1 time unit after edge 0.
  task automatic issue(input logic del, input logic ex, input logic [63:0] r, input logic [31:0] sh);
    @(negedge clkIn);
    delValidIn = del; execValidIn = ex; refNumIn = r; execSharesIn = sh;
    @(posedge clkIn);
    #1;
    delValidIn = 1'b0; execValidIn = 1'b0;
  endtask

  // Starting in the cycle after edge `start`, returns the edge index whose
  // following cycle carries a result pulse (-1 if none within the budget).
  task automatic waitResult(input int start, output int cyc, output logic hit, output logic miss);
    cyc = -1; hit = 1'b0; miss = 1'b0;
    for (int n = start; n < start + 40; n++) begin
      @(negedge clkIn);
      if (delExecValidOut) begin hit = 1'b1; cyc = n; return; end
      if (notFoundOut)     begin miss = 1'b1; cyc = n; return; end
      @(posedge clkIn);
    end
  endtask

  task automatic test_reset;
    vectors++; if (readyOut !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %0b want 1", readyOut); end
    vectors++; if (ramWrEnOut !== 1'b0) begin miscompares++; $display("FAIL reset_wren got %0b want 0", ramWrEnOut); end
    vectors++; if (delExecValidOut !== 1'b0 || notFoundOut !== 1'b0) begin miscompares++; $display("FAIL reset_pulses got %0b%0b want 00", delExecValidOut, notFoundOut); end
    vectors++; if (sharesOut !== 32'd0 || priceOut !== 32'd0 || ramAddrOut !== 4'd0) begin miscompares++; $display("FAIL reset_data got %0h/%0h/%0h want 0", sharesOut, priceOut, ramAddrOut); end
  endtask

  task automatic test_delete_hit;
    int cyc; logic h, m;
    paWrite(4, 64'h1234, '{16'd7, 32'd1000, 32'd50, 1'b1});
    issue(1'b1, 1'b0, 64'h1234, 32'd0);
    waitResult(0, cyc, h, m);
    vectors++; if (!h || cyc != 3) begin miscompares++; $display("FAIL del_timing got hit=%0b edge=%0d want hit=1 edge=3", h, cyc); end
    vectors++; if (sharesOut !== 32'd50 || priceOut !== 32'd1000 || locateOut !== 16'd7 || buySellOut !== 1'b1) begin miscompares++; $display("FAIL del_result got %0d/%0d/%0d/%0b want 50/1000/7/1", sharesOut, priceOut, locateOut, buySellOut); end
    vectors++; if (ramWrEnOut !== 1'b1 || readyOut !== 1'b0 || ramAddrOut !== 4'd4) begin miscompares++; $display("FAIL del_write got we=%0b rdy=%0b addr=%0d want 1/0/4", ramWrEnOut, readyOut, ramAddrOut); end
    @(negedge clkIn);
    vectors++; if (memRef[4] !== TOMBSTONE_REF || memOrd[4] !== '0) begin miscompares++; $display("FAIL del_tomb got %0h/%0h want tombstone/0", memRef[4], memOrd[4]); end
    vectors++; if (readyOut !== 1'b1 || delExecValidOut !== 1'b0) begin miscompares++; $display("FAIL del_after got rdy=%0b v=%0b want 1/0", readyOut, delExecValidOut); end
  endtask

  task automatic test_partial_exec;
    int cyc; logic h, m;
    paWrite(4, 64'h1234, '{16'd7, 32'd1000, 32'd50, 1'b1});
    issue(1'b0, 1'b1, 64'h1234, 32'd20);
    waitResult(0, cyc, h, m);
    vectors++; if (!h || cyc != 3 || sharesOut !== 32'd20) begin miscompares++; $display("FAIL pexec_result got hit=%0b edge=%0d sh=%0d want 1/3/20", h, cyc, sharesOut); end
    @(negedge clkIn);
    vectors++; if (memRef[4] !== 64'h1234 || memOrd[4].shares !== 32'd30 || memOrd[4].price !== 32'd1000 || memOrd[4].locate !== 16'd7) begin miscompares++; $display("FAIL pexec_rewrite got %0h sh=%0d px=%0d want 1234/30/1000", memRef[4], memOrd[4].shares, memOrd[4].price); end
  endtask

  task automatic test_over_exec;
    int cyc; logic h, m;
    issue(1'b0, 1'b1, 64'h1234, 32'd100);
    waitResult(0, cyc, h, m);
    vectors++; if (!h || sharesOut !== 32'd30) begin miscompares++; $display("FAIL oexec_result got hit=%0b sh=%0d want 1/30", h, sharesOut); end
    @(negedge clkIn);
    vectors++; if (memRef[4] !== TOMBSTONE_REF || memOrd[4] !== '0) begin miscompares++; $display("FAIL oexec_tomb got %0h want tombstone", memRef[4]); end
  endtask

  task automatic test_probe_limit;
    int cyc, wc0; logic h, m;
    // Slot 4 is a tombstone; slots 5..15 hold unrelated refs; target sits in slot 0.
    for (int i = 5; i < DEPTH; i++) paWrite(i, 64'hC0DE_0000_0000_0000 + 64'(i), '{16'd1, 32'd1, 32'd1, 1'b0});
    paWrite(0, 64'hABCD_0000_0000_1234, '{16'd2, 32'd2, 32'd2, 1'b0});
    wc0 = wrCount;
    issue(1'b1, 1'b0, 64'hABCD_0000_0000_1234, 32'd0);
    waitResult(0, cyc, h, m);
    vectors++; if (!m || h || cyc != 11) begin miscompares++; $display("FAIL limit_miss got miss=%0b hit=%0b edge=%0d want 1/0/11", m, h, cyc); end
    repeat (3) @(negedge clkIn);
    vectors++; if (wrCount != wc0 || memRef[0] !== 64'hABCD_0000_0000_1234) begin miscompares++; $display("FAIL limit_nowrite got writes=%0d ref0=%0h want 0/abcd000000001234", wrCount - wc0, memRef[0]); end
  endtask

  task automatic test_wrap;
    int cyc; logic h, m;
    // Ref 0xE hashes to 14: probes 14 (other), 15 (tombstone), 0 (hit).
    paWrite(15, TOMBSTONE_REF, '0);
    paWrite(0, 64'hE, '{16'd3, 32'd77, 32'd9, 1'b0});
    issue(1'b0, 1'b1, 64'hE, 32'd4);
    waitResult(0, cyc, h, m);
    vectors++; if (!h || cyc != 9) begin miscompares++; $display("FAIL wrap_timing got hit=%0b edge=%0d want 1/9", h, cyc); end
    vectors++; if (sharesOut !== 32'd4 || priceOut !== 32'd77 || ramAddrOut !== 4'd0 || buySellOut !== 1'b0) begin miscompares++; $display("FAIL wrap_result got sh=%0d px=%0d addr=%0d want 4/77/0", sharesOut, priceOut, ramAddrOut); end
    @(negedge clkIn);
    vectors++; if (memRef[0] !== 64'hE || memOrd[0].shares !== 32'd5) begin miscompares++; $display("FAIL wrap_rewrite got %0h sh=%0d want e/5", memRef[0], memOrd[0].shares); end
  endtask

  task automatic test_empty_miss;
    int cyc, wc0; logic h, m;
    paWrite(4, 64'd0, '0);
    wc0 = wrCount;
    issue(1'b1, 1'b0, 64'h1234, 32'd0);
    waitResult(0, cyc, h, m);
    vectors++; if (!m || cyc != 2) begin miscompares++; $display("FAIL empty_miss got miss=%0b edge=%0d want 1/2", m, cyc); end
    vectors++; if (readyOut !== 1'b0) begin miscompares++; $display("FAIL empty_ready got %0b want 0", readyOut); end
    repeat (3) @(negedge clkIn);
    vectors++; if (wrCount != wc0 || readyOut !== 1'b1) begin miscompares++; $display("FAIL empty_nowrite got writes=%0d rdy=%0b want 0/1", wrCount - wc0, readyOut); end
  endtask

  task automatic test_both_strobes;
    int cyc, wc0; logic h, m;
    paWrite(4, 64'h1234, '{16'd7, 32'd1000, 32'd50, 1'b1});
    wc0 = wrCount;
    issue(1'b1, 1'b1, 64'h1234, 32'd10);
    // A request while busy must be dropped (slot 0 holds ref 0xE).
    delValidIn = 1'b1; refNumIn = 64'hE;
    @(posedge clkIn); #1;
    delValidIn = 1'b0;
    waitResult(1, cyc, h, m);
    vectors++; if (!h || cyc != 3 || sharesOut !== 32'd50) begin miscompares++; $display("FAIL both_result got hit=%0b edge=%0d sh=%0d want 1/3/50", h, cyc, sharesOut); end
    repeat (8) @(negedge clkIn);
    vectors++; if (memRef[4] !== TOMBSTONE_REF) begin miscompares++; $display("FAIL both_tomb got %0h want tombstone", memRef[4]); end
    vectors++; if (wrCount != wc0 + 1 || memRef[0] !== 64'hE) begin miscompares++; $display("FAIL busy_drop got writes=%0d ref0=%0h want 1/e", wrCount - wc0, memRef[0]); end
  endtask

  task automatic test_reset_mid_probe;
    int wc0;
    paWrite(4, 64'h1234, '{16'd7, 32'd1000, 32'd50, 1'b1});
    wc0 = wrCount;
    issue(1'b1, 1'b0, 64'h1234, 32'd0);
    @(posedge clkIn); #2;
    rstNIn = 1'b0;
    #1;
    vectors++; if (readyOut !== 1'b1 || ramWrEnOut !== 1'b0 || sharesOut !== 32'd0 || ramAddrOut !== 4'd0) begin miscompares++; $display("FAIL rst_async got rdy=%0b we=%0b sh=%0d addr=%0d want 1/0/0/0", readyOut, ramWrEnOut, sharesOut, ramAddrOut); end
    repeat (3) @(negedge clkIn);
    rstNIn = 1'b1;
    repeat (6) @(negedge clkIn);
    vectors++; if (readyOut !== 1'b1 || delExecValidOut !== 1'b0 || notFoundOut !== 1'b0) begin miscompares++; $display("FAIL rst_release got rdy=%0b v=%0b nf=%0b want 1/0/0", readyOut, delExecValidOut, notFoundOut); end
    vectors++; if (wrCount != wc0 || memRef[4] !== 64'h1234 || memOrd[4].shares !== 32'd50) begin miscompares++; $display("FAIL rst_ram got writes=%0d ref=%0h sh=%0d want 0/1234/50", wrCount - wc0, memRef[4], memOrd[4].shares); end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin memRef[i] = '0; memOrd[i] = '0; end
    wrCount = 0; paWe = 1'b0; paAddr = '0; paRef = '0; paOrd = '0;
    delValidIn = 1'b0; execValidIn = 1'b0; refNumIn = '0; execSharesIn = '0;
    rstNIn = 1'b0;
    repeat (3) @(negedge clkIn);
    test_reset;
    rstNIn = 1'b1;
    test_delete_hit;
    test_partial_exec;
    test_over_exec;
    test_probe_limit;
    test_wrap;
    test_empty_miss;
    test_both_strobes;
    test_reset_mid_probe;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
